axi_rd_responder: RTL and testbench

// AXI4 read-channel slave (AR/R) backed by a 64-bit-wide word memory. It is the responder
// for the core's instruction-fetch read master and is used in block-level benches and small
// SoC configurations. It serves one burst at a time: INCR, WRAP and FIXED, 64-bit beats.
// A side load port preloads program images.

---
 rtl/axi_pkg.sv | 17 +
 rtl/axi_rd_responder_if.sv | 30 +++
 rtl/axi_burst_addr_gen.sv | 28 ++
 rtl/axi_rd_responder.sv | 148 ++++++++++++++
 tb/tb_axi_rd_responder.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/axi_pkg.sv
// Shared AXI encodings used by the read responder and its address generator.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  typedef logic [1:0] resp_t;
  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  localparam logic [2:0] SIZE_64 = 3'b011;

endpackage

// File: rtl/axi_rd_responder_if.sv
// AXI4 read-channel bundle (AR + R) for the read responder.
interface axi_rd_responder_if #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 64
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [2:0]            size,
  input  burst_t                burst,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic                  wrap_illegal
);
  logic [ADDR_WIDTH-1:0] step, incr, wrap_mask;

  always_comb begin
    step         = ADDR_WIDTH'(1) << size;
    incr         = addr + step;
    // wrap region is (len+1) beats, aligned down to its own size
    wrap_mask    = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    wrap_illegal = !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
      default:     next_addr = incr;
    endcase
  end
endmodule

// File: rtl/axi_rd_responder.sv
// AXI4 read slave backed by a 64-bit word memory; one burst at a time, side preload port.
module axi_rd_responder
  import axi_pkg::*;
#(
  parameter int                    ID_WIDTH   = 13,
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    MEM_WORDS  = 4096,
  parameter logic [ADDR_WIDTH-1:0] MEM_BASE   = '0,
  localparam int                   IDX_W      = $clog2(MEM_WORDS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  axi_rd_responder_if.slave     s_axi,
  input  logic                  ld_en,
  input  logic [IDX_W-1:0]      ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data
);
  typedef enum logic {IDLE, BEAT} rd_state_t;

  rd_state_t             state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q, beat_q;
  logic [2:0]            size_q;
  burst_t                burst_q;
  logic                  arready_q, rvalid_q, rlast_q, rok_q;
  resp_t                 rresp_q;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic [ADDR_WIDTH-1:0] ag_addr, next_addr, rd_addr, rd_off;
  logic [7:0]            ag_len;
  logic [2:0]            ag_size;
  burst_t                ag_burst;
  logic                  wrap_illegal, burst_err, rd_err, ar_hs, r_hs, rd_en, ld_ok;
  logic [IDX_W-1:0]      rd_idx;

  // In IDLE the generator sees the incoming request so its legality is known at accept time.
  assign ag_addr  = (state_q == IDLE) ? s_axi.araddr           : addr_q;
  assign ag_len   = (state_q == IDLE) ? s_axi.arlen            : len_q;
  assign ag_size  = (state_q == IDLE) ? s_axi.arsize           : size_q;
  assign ag_burst = (state_q == IDLE) ? burst_t'(s_axi.arburst) : burst_q;

  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
    .addr         (ag_addr),
    .len          (ag_len),
    .size         (ag_size),
    .burst        (ag_burst),
    .next_addr    (next_addr),
    .wrap_illegal (wrap_illegal)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ar_hs   = 1'b0;
    r_hs    = 1'b0;
    rd_en   = 1'b0;
    rd_addr = addr_q;
    case (state_q)
      IDLE: begin
        ar_hs = arready_q && s_axi.arvalid;
        if (ar_hs) begin
          rd_en   = 1'b1;
          rd_addr = s_axi.araddr;
          state_d = BEAT;
        end
      end
      BEAT: begin
        r_hs = rvalid_q && s_axi.rready;
        if (r_hs) begin
          if (beat_q == len_q) begin
            state_d = IDLE;
          end else begin
            rd_en   = 1'b1;
            rd_addr = next_addr;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign burst_err = (ag_size != SIZE_64) || (ag_burst == BURST_RSVD) ||
                     (ag_burst == BURST_WRAP && wrap_illegal);
  assign rd_off    = rd_addr - MEM_BASE;
  assign rd_err    = burst_err || ((rd_off >> 3) >= ADDR_WIDTH'(MEM_WORDS));
  assign rd_idx    = rd_off[IDX_W+2:3];
  assign ld_ok     = {{(32-IDX_W){1'b0}}, ld_addr} < 32'(MEM_WORDS);

  // Plain array so it maps to a RAM; a same-edge read sees the pre-write word.
  always_ff @(posedge clk) begin
    if (ld_en && ld_ok) mem[ld_addr] <= ld_data;
    if (rd_en)          rd_word      <= mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rok_q     <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      size_q    <= '0;
      burst_q   <= BURST_FIXED;
    end else begin
      arready_q <= (state_d == IDLE);
      rvalid_q  <= (state_d == BEAT);
      if (ar_hs) begin
        id_q    <= s_axi.arid;
        addr_q  <= s_axi.araddr;
        len_q   <= s_axi.arlen;
        size_q  <= s_axi.arsize;
        burst_q <= burst_t'(s_axi.arburst);
        beat_q  <= '0;
        rlast_q <= (s_axi.arlen == 8'd0);
      end else if (r_hs) begin
        if (beat_q == len_q) begin
          rlast_q <= 1'b0;
        end else begin
          beat_q  <= beat_q + 8'd1;
          addr_q  <= next_addr;
          rlast_q <= (beat_q + 8'd1 == len_q);
        end
      end
      if (rd_en) begin
        rresp_q <= rd_err ? RESP_SLVERR : RESP_OKAY;
        rok_q   <= !rd_err;
      end
    end
  end

  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rlast   = rlast_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rid     = id_q;
  assign s_axi.rdata   = rok_q ? rd_word : '0;
endmodule

// File: tb/tb_axi_rd_responder.sv
// Directed bench for axi_rd_responder: expected beats queued at AR time, checked as R beats arrive.
module tb_axi_rd_responder;
  localparam int MEM_WORDS = 4096;
  localparam int IDX_W     = $clog2(MEM_WORDS);

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  logic clk, reset_n, ld_en;
  logic [IDX_W-1:0] ld_addr;
  logic [63:0]      ld_data;

  axi_rd_responder_if #(.ID_WIDTH(13), .ADDR_WIDTH(64), .DATA_WIDTH(64)) bus ();

  axi_rd_responder #(
    .ID_WIDTH(13), .ADDR_WIDTH(64), .DATA_WIDTH(64), .MEM_WORDS(MEM_WORDS), .MEM_BASE(64'h0)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .s_axi   (bus),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_pass = 0;
  beat_t       sb[$];
  logic [63:0] mdl [MEM_WORDS];
  logic [12:0] exp_id;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load(input int idx, input logic [63:0] d);
    ld_en = 1'b1; ld_addr = IDX_W'(idx); ld_data = d;
    tick();
    ld_en = 1'b0;
    mdl[idx] = d;
  endtask

  function automatic void push_burst(input logic [63:0] addr, input logic [7:0] len,
                                     input logic [2:0] size, input logic [1:0] burst);
    logic [63:0] region, base, a, w;
    logic berr;
    beat_t b;
    region = (64'(len) + 64'd1) * 64'd8;
    base   = addr - (addr % region);
    berr   = (size != 3'd3) || (burst == 2'b11) ||
             (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
    for (int i = 0; i <= int'(len); i++) begin
      case (burst)
        2'b00:   a = addr;
        2'b10:   a = base + (((addr - base) + 64'(8 * i)) % region);
        default: a = addr + 64'(8 * i);
      endcase
      w      = a >> 3;
      b.resp = (berr || w >= 64'(MEM_WORDS)) ? 2'b10 : 2'b00;
      b.data = (b.resp == 2'b00) ? mdl[w[11:0]] : 64'd0;
      b.last = (i == int'(len));
      sb.push_back(b);
    end
  endfunction

  task automatic set_ar(input logic [12:0] id, input logic [63:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
    int cyc = 0;
    push_burst(addr, len, size, burst);
    exp_id = id;
    while (!bus.arready && cyc < 50) begin tick(); cyc++; end
    chk("ar_wait", 64'(cyc < 50), 64'd1);
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
    bus.arvalid = 1'b1;
  endtask

  // Consumes up to max_pop beats; rready follows pat[k % plen].
  task automatic collect(input logic [7:0] pat, input int plen, input int max_pop);
    int k = 0, cyc = 0, popped = 0;
    chk("r_latency", 64'(bus.rvalid), 64'd1);
    while (sb.size() > 0 && popped < max_pop && cyc < 300) begin
      bus.rready = pat[k % plen];
      k++;
      if (bus.rvalid) begin
        chk("rdata", bus.rdata, sb[0].data);
        chk("rresp", 64'(bus.rresp), 64'(sb[0].resp));
        chk("rlast", 64'(bus.rlast), 64'(sb[0].last));
        chk("rid", 64'(bus.rid), 64'(exp_id));
        if (bus.rready) begin void'(sb.pop_front()); popped++; end
      end
      tick();
      cyc++;
    end
    bus.rready = 1'b0;
    chk("r_budget", 64'(cyc < 300), 64'd1);
    if (sb.size() == 0) begin
      chk("gap_arready", 64'(bus.arready), 64'd1);
      chk("gap_rvalid", 64'(bus.rvalid), 64'd0);
    end
  endtask

  task automatic run_burst(input logic [12:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input logic [7:0] pat, input int plen);
    set_ar(id, addr, len, size, burst);
    tick();
    bus.arvalid = 1'b0;
    collect(pat, plen, 256);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
    bus.arvalid = 1'b0; bus.rready = 1'b0;
    tick(); tick();
    chk("rst_arready", 64'(bus.arready), 64'd0);
    chk("rst_rvalid", 64'(bus.rvalid), 64'd0);
    chk("rst_rlast", 64'(bus.rlast), 64'd0);
    chk("rst_rresp", 64'(bus.rresp), 64'd0);
    chk("rst_rid", 64'(bus.rid), 64'd0);
    chk("rst_rdata", bus.rdata, 64'd0);
    reset_n = 1'b1;
    tick();
    chk("rst_release_arready", 64'(bus.arready), 64'd1);

    for (int i = 0; i < 8; i++) load(i, 64'h10 + 64'(i));
    load(MEM_WORDS - 1, 64'hDEAD_BEEF_0000_0FFF);

    // WRAP len 7 from word 2
    run_burst(13'd5, 64'h10, 8'd7, 3'd3, 2'b10, 8'hFF, 1);
    // INCR with stalled rready 1,0,0
    run_burst(13'd9, 64'h0, 8'd3, 3'd3, 2'b01, 8'b0000_0001, 3);
    // INCR running off the end of memory
    run_burst(13'd1, 64'((MEM_WORDS - 1) * 8), 8'd1, 3'd3, 2'b01, 8'hFF, 1);
    // whole-burst errors
    run_burst(13'd2, 64'h0, 8'd2, 3'd3, 2'b10, 8'hFF, 1);
    run_burst(13'd3, 64'h0, 8'd3, 3'd2, 2'b01, 8'hFF, 1);
    run_burst(13'd4, 64'h8, 8'd1, 3'd3, 2'b11, 8'hFF, 1);
    // FIXED
    run_burst(13'h1ABC, 64'h18, 8'd2, 3'd3, 2'b00, 8'b0000_0101, 3);

    // Reset while beat 3 of an 8-beat burst is presented
    set_ar(13'd7, 64'h0, 8'd7, 3'd3, 2'b01);
    tick();
    bus.arvalid = 1'b0;
    collect(8'hFF, 1, 2);
    chk("abort_rvalid_before", 64'(bus.rvalid), 64'd1);
    reset_n = 1'b0;
    tick();
    chk("abort_rvalid", 64'(bus.rvalid), 64'd0);
    chk("abort_rlast", 64'(bus.rlast), 64'd0);
    chk("abort_arready", 64'(bus.arready), 64'd0);
    sb.delete();
    reset_n = 1'b1;
    tick();
    chk("abort_rel_arready", 64'(bus.arready), 64'd1);
    run_burst(13'd8, 64'h0, 8'd7, 3'd3, 2'b01, 8'hFF, 1);

    // Load to word 4 on the same edge the burst reads it
    set_ar(13'd6, 64'h20, 8'd0, 3'd3, 2'b01);
    ld_en = 1'b1; ld_addr = IDX_W'(4); ld_data = 64'hCAFE_0004;
    tick();
    bus.arvalid = 1'b0; ld_en = 1'b0;
    mdl[4] = 64'hCAFE_0004;
    collect(8'hFF, 1, 256);
    run_burst(13'd6, 64'h20, 8'd0, 3'd3, 2'b01, 8'hFF, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
